// File: rtl/quant_pkg.sv
// Shared constants, state encoding and helpers for the quantizer sequencer.
package quant_pkg;

    localparam int IDX_W        = 8;
    localparam int ACT_W        = 32;
    localparam int DIV_STAGES   = 8;
    // quant_pre plus one cycle per divider stage
    localparam int PIPE_LAT_DEF = DIV_STAGES + 1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_SCAN      = 3'd1;
    localparam state_t ST_SCAN_WAIT = 3'd2;
    localparam state_t ST_QUANT     = 3'd3;
    localparam state_t ST_DRAIN     = 3'd4;
    localparam state_t ST_DONE      = 3'd5;

    function automatic logic [ACT_W-1:0] max_sel(input logic [ACT_W-1:0] cur,
                                                 input logic [ACT_W-1:0] dat);
        if (dat > cur) begin
            return dat;
        end else begin
            return cur;
        end
    endfunction

endpackage

// File: rtl/quant_ctrl_if.sv
// Control, buffer-read, quantizer and index-stream signals of quant_ctrl.
interface quant_ctrl_if
    import quant_pkg::*;
#(
    parameter int LEN_W = 10
);
    logic             i_start;
    logic [LEN_W-1:0] i_len;
    logic             o_busy;
    logic             o_done;
    logic             o_rd_en;
    logic [LEN_W-1:0] o_rd_addr;
    logic [ACT_W-1:0] i_rd_data;
    logic [ACT_W-1:0] o_q_max;
    logic [ACT_W-1:0] o_q_activation;
    logic [IDX_W-1:0] i_q_index;
    logic             o_idx_valid;
    logic [IDX_W-1:0] o_idx_data;
    logic             i_idx_ready;

    modport slave (
        input  i_start, i_len, i_rd_data, i_q_index, i_idx_ready,
        output o_busy, o_done, o_rd_en, o_rd_addr, o_q_max, o_q_activation,
               o_idx_valid, o_idx_data
    );

    modport master (
        output i_start, i_len, i_rd_data, i_q_index, i_idx_ready,
        input  o_busy, o_done, o_rd_en, o_rd_addr, o_q_max, o_q_activation,
               o_idx_valid, o_idx_data
    );
endinterface

// File: rtl/quant_idx_fifo.sv
// Synchronous FIFO with occupancy count; output data reads 0 while empty.
module quant_idx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             valid,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             rd_ok_s;
    logic             wr_ok_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_ONE;
        end
    endfunction

    assign rd_ok_s = pop && (count_r != {CNT_W{1'b0}});
    assign wr_ok_s = push && ((count_r != CNT_FULL) || rd_ok_s);

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care while the matching slot is empty.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign valid    = (count_r != {CNT_W{1'b0}});
    assign pop_data = valid ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
    assign count    = count_r;

endmodule

// File: rtl/quant_ctrl.sv
// Two-pass tile sequencer: max scan, then credit-throttled streaming through
// the fixed-latency quantizer with tag-aligned capture into an output FIFO.
module quant_ctrl
    import quant_pkg::*;
#(
    parameter int LEN_W      = 10,
    parameter int PIPE_LAT   = PIPE_LAT_DEF,
    parameter int FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    quant_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W:0]   SUM_ONE   = (CNT_W + 1)'(1);
    localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
    localparam logic [ACT_W-1:0] ACT_ONE   = ACT_W'(1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   addr_r;
    logic [LEN_W-1:0]   rd_addr_r;
    logic               rd_en_r;
    logic [ACT_W-1:0]   max_r;
    logic               scan_vld_r;
    logic               act_vld_r;
    logic [PIPE_LAT:0]  tag_r;
    logic [CNT_W-1:0]   inflight_r;
    logic               busy_r;
    logic               done_r;

    logic [CNT_W-1:0]   fifo_count_s;
    logic               fifo_valid_s;
    logic               push_s;
    logic               pop_s;
    logic               credit_ok_s;
    logic               issue_s;
    logic               last_strobe_s;
    logic               qstrobe_s;
    logic [ACT_W-1:0]   max_upd_s;

    assign push_s        = tag_r[PIPE_LAT];
    assign pop_s         = fifo_valid_s && bus.i_idx_ready;
    // Credits cover both buffered results and reads already committed to the pipe.
    assign credit_ok_s   = (({1'b0, fifo_count_s} + {1'b0, inflight_r} + SUM_ONE) <= DEPTH_C);
    assign issue_s       = (state_r == ST_QUANT) && (addr_r != len_r) && credit_ok_s;
    assign last_strobe_s = rd_en_r && (rd_addr_r == (len_r - LEN_ONE));
    assign qstrobe_s     = rd_en_r && (state_r == ST_QUANT);
    assign max_upd_s     = max_sel(max_r, bus.i_rd_data);

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_nxt_s = (bus.i_len == {LEN_W{1'b0}}) ? ST_DONE : ST_SCAN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (last_strobe_s) begin
                    state_nxt_s = ST_SCAN_WAIT;
                end else begin
                    state_nxt_s = ST_SCAN;
                end
            end
            ST_SCAN_WAIT: state_nxt_s = ST_QUANT;
            ST_QUANT: begin
                if (last_strobe_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_QUANT;
                end
            end
            ST_DRAIN: begin
                if ((inflight_r == {CNT_W{1'b0}}) && (fifo_count_s == {CNT_W{1'b0}})) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Sequencer state, read strobe generation, max tracking, tags and credits.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            len_r      <= {LEN_W{1'b0}};
            addr_r     <= {LEN_W{1'b0}};
            rd_addr_r  <= {LEN_W{1'b0}};
            rd_en_r    <= 1'b0;
            max_r      <= {ACT_W{1'b0}};
            scan_vld_r <= 1'b0;
            act_vld_r  <= 1'b0;
            tag_r      <= {(PIPE_LAT + 1){1'b0}};
            inflight_r <= {CNT_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
            done_r     <= (state_nxt_s == ST_DONE);
            scan_vld_r <= rd_en_r && (state_r == ST_SCAN);
            act_vld_r  <= qstrobe_s;
            tag_r      <= {tag_r[PIPE_LAT-1:0], qstrobe_s};

            case ({issue_s, push_s})
                2'b10:   inflight_r <= inflight_r + CNT_ONE;
                2'b01:   inflight_r <= inflight_r - CNT_ONE;
                default: inflight_r <= inflight_r;
            endcase

            case (state_r)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        len_r     <= bus.i_len;
                        max_r     <= {ACT_W{1'b0}};
                        addr_r    <= {LEN_W{1'b0}};
                        rd_addr_r <= {LEN_W{1'b0}};
                        rd_en_r   <= (bus.i_len != {LEN_W{1'b0}});
                    end else begin
                        rd_en_r   <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (scan_vld_r) begin
                        max_r <= max_upd_s;
                    end
                    if (last_strobe_s) begin
                        rd_en_r   <= 1'b0;
                    end else begin
                        rd_en_r   <= 1'b1;
                        rd_addr_r <= rd_addr_r + LEN_ONE;
                    end
                end
                ST_SCAN_WAIT: begin
                    // A zero maximum would be a zero divisor downstream.
                    max_r     <= (max_upd_s == {ACT_W{1'b0}}) ? ACT_ONE : max_upd_s;
                    rd_en_r   <= 1'b0;
                    rd_addr_r <= {LEN_W{1'b0}};
                    addr_r    <= {LEN_W{1'b0}};
                end
                ST_QUANT: begin
                    rd_en_r <= issue_s;
                    if (issue_s) begin
                        rd_addr_r <= addr_r;
                        addr_r    <= addr_r + LEN_ONE;
                    end
                end
                default: begin
                    rd_en_r <= 1'b0;
                end
            endcase
        end
    end

    quant_idx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (IDX_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_s),
        .push_data (bus.i_q_index),
        .pop       (pop_s),
        .pop_data  (bus.o_idx_data),
        .valid     (fifo_valid_s),
        .count     (fifo_count_s)
    );

    assign bus.o_busy         = busy_r;
    assign bus.o_done         = done_r;
    assign bus.o_rd_en        = rd_en_r;
    assign bus.o_rd_addr      = rd_addr_r;
    assign bus.o_q_max        = max_r;
    assign bus.o_q_activation = act_vld_r ? bus.i_rd_data : {ACT_W{1'b0}};
    assign bus.o_idx_valid    = fifo_valid_s;

endmodule

// File: tb/tb_quant_ctrl.sv
// Self-checking bench for quant_ctrl with a buffer model and a delayed quantizer model.
module tb_quant_ctrl;
    import quant_pkg::*;

    localparam int LEN_W      = 10;
    localparam int FIFO_DEPTH = 16;
    localparam int PIPE_LAT   = PIPE_LAT_DEF;

    typedef struct packed {
        logic [7:0]        len;
        logic [3:0][31:0]  d;
        logic [31:0]       emax;
        logic [3:0][7:0]   e;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;

    quant_ctrl_if #(.LEN_W(LEN_W)) bus ();

    quant_ctrl #(
        .LEN_W      (LEN_W),
        .PIPE_LAT   (PIPE_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [64];
    logic [7:0]  exp_idx [64];
    logic [7:0]  qpipe   [PIPE_LAT];
    vec_t        vecs    [5];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [7:0] qfn(input logic [31:0] act, input logic [31:0] mx);
        logic [63:0] p;
        if (mx == 32'd0) return 8'd0;
        p = (64'(act) * 64'd255) / 64'(mx);
        return p[7:0];
    endfunction

    function automatic vec_t mk(input int len, input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3, input logic [31:0] emax,
                                input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                                input logic [7:0] e3);
        vec_t v;
        v.len = len[7:0];
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.emax = emax;
        v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
        return v;
    endfunction

    // Buffer with one-cycle read latency; garbage when no read was issued.
    always @(posedge clk) begin
        if (bus.o_rd_en) bus.i_rd_data <= mem[bus.o_rd_addr[5:0]];
        else             bus.i_rd_data <= 32'hDEAD_BEEF;
    end

    // Quantizer: scaled index, PIPE_LAT cycles after its inputs.
    always @(posedge clk) begin
        qpipe[0] <= qfn(bus.o_q_activation, bus.o_q_max);
        for (int i = 1; i < PIPE_LAT; i++) qpipe[i] <= qpipe[i-1];
    end
    assign bus.i_q_index = qpipe[PIPE_LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_tile(input int len, input logic [31:0] emax, input int hold, input bit inject);
        int nstr = 0, qstr = 0, nout = 0, ndone = 0, done_cyc = -1, max_out = 0;
        int hold_left = hold;
        int pend_addr = 0;
        bit pend = 1'b0, injected = 1'b0, done_seen = 1'b0;
        @(negedge clk);
        bus.i_start     = 1'b1;
        bus.i_len       = LEN_W'(len);
        bus.i_idx_ready = (hold == 0);
        @(posedge clk);
        for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
            @(negedge clk);
            if (inject && nstr == 2 && !injected) begin
                bus.i_start = 1'b1;
                bus.i_len   = LEN_W'(9);
                injected    = 1'b1;
            end else begin
                bus.i_start = 1'b0;
            end
            if (cyc == 0) check("busy_after_start", bus.o_busy, 1);
            if (pend) begin
                check("activation", bus.o_q_activation, mem[pend_addr]);
                pend = 1'b0;
            end
            if (bus.o_rd_en) begin
                if (nstr < len) begin
                    check("scan_addr", bus.o_rd_addr, nstr);
                end else begin
                    check("quant_addr", bus.o_rd_addr, nstr - len);
                    check("q_max", bus.o_q_max, emax);
                    pend      = 1'b1;
                    pend_addr = nstr - len;
                    qstr++;
                end
                nstr++;
            end
            if (qstr - nout > max_out) max_out = qstr - nout;
            if (hold > 0 && qstr > 0 && hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) begin
                    check("stall_at_depth", qstr, FIFO_DEPTH);
                    bus.i_idx_ready = 1'b1;
                end
            end
            if (bus.o_idx_valid && bus.i_idx_ready) begin
                if (nout < len) check("index", bus.o_idx_data, exp_idx[nout]);
                nout++;
            end
            if (bus.o_done) begin
                ndone++;
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
        end
        bus.i_start = 1'b0;
        @(negedge clk);
        check("done_count", ndone, 1);
        check("busy_after_done", bus.o_busy, 0);
        check("done_one_cycle", bus.o_done, 0);
        check("valid_after_done", bus.o_idx_valid, 0);
        check("act_zero_idle", bus.o_q_activation, 0);
        check("out_count", nout, len);
        check("strobe_count", nstr, 2 * len);
        check("outstanding_le_depth", (max_out <= FIFO_DEPTH), 1);
        if (len == 0) check("done_latency", done_cyc, 0);
    endtask

    initial begin
        int nvalid;
        bit found;
        reset_n         = 1'b0;
        bus.i_start     = 1'b0;
        bus.i_len       = '0;
        bus.i_idx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("rst_busy",  bus.o_busy, 0);
        check("rst_done",  bus.o_done, 0);
        check("rst_rd_en", bus.o_rd_en, 0);
        check("rst_addr",  bus.o_rd_addr, 0);
        check("rst_max",   bus.o_q_max, 0);
        check("rst_act",   bus.o_q_activation, 0);
        check("rst_valid", bus.o_idx_valid, 0);
        check("rst_data",  bus.o_idx_data, 0);

        vecs[0] = mk(4, 32'd10, 32'd20, 32'd40, 32'd5, 32'd40, 8'd63, 8'd127, 8'd255, 8'd31);
        vecs[1] = mk(3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 8'd0, 8'd0, 8'd0, 8'd0);
        vecs[2] = mk(1, 32'd7, 32'd0, 32'd0, 32'd0, 32'd7, 8'd255, 8'd0, 8'd0, 8'd0);
        vecs[3] = mk(4, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF,
                     8'd255, 8'd0, 8'd127, 8'd0);
        vecs[4] = mk(2, 32'd3, 32'd300, 32'd0, 32'd0, 32'd300, 8'd2, 8'd255, 8'd0, 8'd0);

        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) begin
                mem[i]     = vecs[k].d[i];
                exp_idx[i] = vecs[k].e[i];
            end
            run_tile(int'(vecs[k].len), vecs[k].emax, 0, 1'b0);
        end

        run_tile(0, 32'd0, 0, 1'b0);

        // Backpressure: 64 samples, maximum 190, output stalled 50 cycles.
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'(i * 3 + 1);
            exp_idx[i] = qfn(mem[i], 32'd190);
        end
        run_tile(64, 32'd190, 50, 1'b0);

        // Start pulse during SCAN carrying a different length.
        for (int i = 0; i < 4; i++) begin
            mem[i]     = vecs[0].d[i];
            exp_idx[i] = vecs[0].e[i];
        end
        run_tile(4, 32'd40, 0, 1'b1);

        // Reset after five quantize-pass reads.
        for (int i = 0; i < 8; i++) mem[i] = 32'(100 + i);
        @(negedge clk);
        bus.i_start     = 1'b1;
        bus.i_len       = LEN_W'(8);
        bus.i_idx_ready = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        found = 1'b0;
        nvalid = 0;
        for (int cyc = 0; cyc < 300 && !found; cyc++) begin
            if (bus.o_rd_en) nvalid++;
            if (nvalid == 13) found = 1'b1;
            else @(negedge clk);
        end
        check("reset_setup", found, 1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("midrst_busy",  bus.o_busy, 0);
        check("midrst_valid", bus.o_idx_valid, 0);
        check("midrst_rd_en", bus.o_rd_en, 0);
        check("midrst_max",   bus.o_q_max, 0);
        nvalid = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (bus.o_idx_valid) nvalid++;
        end
        check("no_stale_push", nvalid, 0);
        mem[0] = 32'd50;  exp_idx[0] = 8'd255;
        mem[1] = 32'd25;  exp_idx[1] = 8'd127;
        run_tile(2, 32'd50, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
